alu_seq_core: RTL

Parametrised, registered successor to the 8-bit combinational ALU: a WIDTH-bit ALU with valid/ready handshakes on input and output, a sticky carry flag for multi-word add/subtract chains, full status flags and an iterative unsigned multiplier. It sits between the pin-level operand/opcode capture logic and the result/flag output mux. Legacy opcodes 0–7 keep their original meaning; opcodes 8–12 are new.

---
 rtl/alu_seq_core.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_core.sv
// alu_seq_core: registered WIDTH-bit ALU with valid/ready handshakes,
// a sticky carry for multi-word ADC/SBB chains, full status flags and an
// iterative (one shift-add step per cycle) unsigned multiplier.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake for a, b, op
//   a, b                  WIDTH-bit operands
//   op                    4-bit opcode (0-7 legacy, 8-12 extended, 13-15 reserved)
//   out_valid / out_ready output handshake for result and flags
//   result, result_hi     result (MUL: low/high product halves; hi=0 otherwise)
//   carry, zero, neg, ovf status flags for the held result
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
        OP_XOR  = 4'd4,  OP_SHL = 4'd5,  OP_SHR = 4'd6,  OP_ADD2 = 4'd7,
        OP_ADC  = 4'd8,  OP_SBB = 4'd9,  OP_SAR = 4'd10, OP_ROL = 4'd11,
        OP_MUL  = 4'd12
    } op_e;

    state_e             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic               c_flag;

    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic               mul_start;
    logic               wr_single;
    logic               wr_mul;

    logic [WIDTH-1:0]   bb;
    logic               cin;
    logic               arith;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_carry;
    logic               sc_ovf;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (op_e'(op) == OP_MUL);
    assign mul_done = (cnt == CW'(WIDTH - 1));
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Single-cycle datapath. All add/sub variants share one WIDTH+1 bit adder:
    // subtraction inverts b, and the carry-in is 1 (SUB) or the sticky C (ADC/SBB).
    always_comb begin
        bb       = b;
        cin      = 1'b0;
        arith    = 1'b0;
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (op_e'(op))
            OP_ADD, OP_ADD2: arith = 1'b1;
            OP_SUB: begin bb = ~b; cin = 1'b1;   arith = 1'b1; end
            OP_ADC: begin          cin = c_flag; arith = 1'b1; end
            OP_SBB: begin bb = ~b; cin = c_flag; arith = 1'b1; end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_SHL: begin sc_res = {a[MSB-1:0], 1'b0};  sc_carry = a[MSB]; end
            OP_SHR: begin sc_res = {1'b0, a[MSB:1]};    sc_carry = a[0];   end
            OP_SAR: begin sc_res = {a[MSB], a[MSB:1]};  sc_carry = a[0];   end
            OP_ROL: begin sc_res = {a[MSB-1:0], a[MSB]}; sc_carry = a[MSB]; end
            default: ;
        endcase
        sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
        if (arith) begin
            sc_res   = sum[MSB:0];
            sc_carry = sum[WIDTH];
            sc_ovf   = (a[MSB] == bb[MSB]) && (sum[MSB] != a[MSB]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        wr_single  = 1'b0;
        wr_mul     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start  = 1'b1;
                        state_next = S_MUL;
                    end else begin
                        wr_single = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    wr_mul     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            c_flag    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (mul_start) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == S_MUL) begin
                // Multiplicand moves left while the multiplier is consumed LSB first.
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= mul_done ? '0 : cnt + 1'b1;
            end

            if (wr_single) begin
                result    <= sc_res;
                result_hi <= '0;
                carry     <= sc_carry;
                zero      <= (sc_res == '0);
                neg       <= sc_res[MSB];
                ovf       <= sc_ovf;
                c_flag    <= sc_carry;
            end else if (wr_mul) begin
                result    <= acc_next[MSB:0];
                result_hi <= acc_next[2*WIDTH-1:WIDTH];
                carry     <= |acc_next[2*WIDTH-1:WIDTH];
                zero      <= (acc_next == '0);
                neg       <= acc_next[2*WIDTH-1];
                ovf       <= 1'b0;
                c_flag    <= |acc_next[2*WIDTH-1:WIDTH];
            end

            // A result written this edge wins over consumption of the previous one.
            if (wr_single || wr_mul) out_valid <= 1'b1;
            else if (out_ready)      out_valid <= 1'b0;
        end
    end

endmodule
